// File: rtl/lsu_mem_stage.sv
// Memory stage of the load/store unit: accepts one request from execute, runs a
// single 64-bit bus transaction, and returns the aligned, extended load data.
module lsu_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  output logic        lsu_busy,
  output logic        mem_done,
  output logic [63:0] mem_rdata,
  output logic        lsu_misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [63:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic        req_load;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [2:0]  req_off;

  logic        start;
  logic        is_store;
  logic        aligned;
  logic [7:0]  strb_base;
  logic [63:0] size_mask;
  logic [7:0]  store_strb;
  logic [63:0] store_data;
  logic [63:0] rd_shift;
  logic [63:0] load_ext;

  assign start    = ex_valid & (ex_load | ex_store);
  // A request with both type bits set is treated as a load.
  assign is_store = ex_store & ~ex_load;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    aligned   = 1'b1;
    strb_base = 8'h01;
    case (ex_size)
      2'b00: begin aligned = 1'b1;                  strb_base = 8'h01; end
      2'b01: begin aligned = ~ex_addr[0];           strb_base = 8'h03; end
      2'b10: begin aligned = (ex_addr[1:0] == 2'b0); strb_base = 8'h0F; end
      default: begin aligned = (ex_addr[2:0] == 3'b0); strb_base = 8'hFF; end
    endcase
  end

  always_comb begin
    size_mask = '0;
    for (int i = 0; i < 8; i++) size_mask[8*i +: 8] = {8{strb_base[i]}};
  end

  assign store_strb = strb_base << ex_addr[2:0];
  // Bytes beyond the access size are cleared so only the strobed lanes carry data.
  assign store_data = (ex_wdata & size_mask) << {ex_addr[2:0], 3'b000};

  assign rd_shift = bus_rdata >> {req_off, 3'b000};

  always_comb begin
    load_ext = rd_shift;
    case (req_size)
      2'b00: load_ext = req_unsigned ? {56'b0, rd_shift[7:0]}
                                     : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'b01: load_ext = req_unsigned ? {48'b0, rd_shift[15:0]}
                                     : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'b10: load_ext = req_unsigned ? {32'b0, rd_shift[31:0]}
                                     : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: load_ext = rd_shift;
    endcase
  end

  assign lsu_busy = (state != S_IDLE);
  assign mem_done = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      req_load     <= 1'b0;
      req_size     <= 2'b0;
      req_unsigned <= 1'b0;
      req_off      <= 3'b0;
      lsu_misalign <= 1'b0;
      mem_rdata    <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_wstrb    <= '0;
    end else begin
      lsu_misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (aligned) begin
              state        <= S_REQ;
              req_load     <= ~is_store;
              req_size     <= ex_size;
              req_unsigned <= ex_unsigned;
              req_off      <= ex_addr[2:0];
              bus_req      <= 1'b1;
              bus_we       <= is_store;
              bus_addr     <= {ex_addr[63:3], 3'b000};
              bus_wdata    <= is_store ? store_data : 64'b0;
              bus_wstrb    <= is_store ? store_strb : 8'b0;
            end else begin
              lsu_misalign <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            state     <= S_DONE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wstrb <= 8'b0;
            mem_rdata <= req_load ? load_ext : 64'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a vector table for single-cycle-ack accesses
// plus hand-written sequences for delayed ack, reset in flight and ignored requests.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_load, ex_store, ex_unsigned;
  logic [1:0]  ex_size;
  logic [63:0] ex_addr, ex_wdata;
  logic        lsu_busy, mem_done, lsu_misalign;
  logic [63:0] mem_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .lsu_busy(lsu_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .lsu_misalign(lsu_misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        mis;
    logic        we;
    logic [7:0]  strb;
    logic [63:0] baddr;
    logic [63:0] bwdata;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];
  logic [63:0] last_rdata;
  logic [63:0] lane_mask;
  logic [63:0] held_addr;
  int          done_pulses;

  task automatic drive_req(input logic ld, input logic st, input logic [1:0] size,
                           input logic uns, input logic [63:0] addr, input logic [63:0] wdata);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_size = size;
    ex_unsigned = uns; ex_addr = addr; ex_wdata = wdata;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_size = 2'b00;
    ex_unsigned = 1'b0; ex_addr = '0; ex_wdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_req"},   bus_req, 1'b0);
    check({tag, "_bus_we"},    bus_we, 1'b0);
    check({tag, "_bus_wstrb"}, bus_wstrb, 8'h00);
    check({tag, "_bus_addr"},  bus_addr, 64'h0);
    check({tag, "_bus_wdata"}, bus_wdata, 64'h0);
    check({tag, "_busy"},      lsu_busy, 1'b0);
    check({tag, "_done"},      mem_done, 1'b0);
    check({tag, "_misalign"},  lsu_misalign, 1'b0);
    check({tag, "_rdata"},     mem_rdata, 64'h0);
  endtask

  initial begin
    //         ld    st    size   uns   addr                   wdata                  rdata                  mis   we    strb   baddr                  bwdata                 exp_rdata
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 64'h0000_0000_8000_0003, 64'h0,                 64'h0000_0000_8000_0000, 1'b0, 1'b0, 8'h00, 64'h0000_0000_8000_0000, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_1234, 64'h0,                 1'b0, 1'b1, 8'hC0, 64'h0000_0000_8000_0000, 64'h1234_0000_0000_0000, 64'h0};
    vecs[2]  = '{1'b1, 1'b0, 2'b10, 1'b1, 64'h0000_0000_8000_0002, 64'h0,                 64'h0,                 1'b1, 1'b0, 8'h00, 64'h0,                 64'h0,                 64'h0};
    vecs[3]  = '{1'b1, 1'b0, 2'b10, 1'b0, 64'h0000_0000_8000_0004, 64'h0,                 64'h8765_4321_0000_0000, 1'b0, 1'b0, 8'h00, 64'h0000_0000_8000_0000, 64'h0,                 64'hFFFF_FFFF_8765_4321};
    vecs[4]  = '{1'b1, 1'b0, 2'b10, 1'b1, 64'h0000_0000_8000_0004, 64'h0,                 64'h8765_4321_0000_0000, 1'b0, 1'b0, 8'h00, 64'h0000_0000_8000_0000, 64'h0,                 64'h0000_0000_8765_4321};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, 1'b1, 64'h0000_0000_0000_1002, 64'h0,                 64'h0000_0000_BEEF_0000, 1'b0, 1'b0, 8'h00, 64'h0000_0000_0000_1000, 64'h0,                 64'h0000_0000_0000_BEEF};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 1'b0, 64'h0000_0000_0000_1002, 64'h0,                 64'h0000_0000_BEEF_0000, 1'b0, 1'b0, 8'h00, 64'h0000_0000_0000_1000, 64'h0,                 64'hFFFF_FFFF_FFFF_BEEF};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 1'b1, 64'h0000_0000_0000_0007, 64'h0,                 64'hA500_0000_0000_0000, 1'b0, 1'b0, 8'h00, 64'h0,                 64'h0,                 64'h0000_0000_0000_00A5};
    vecs[8]  = '{1'b1, 1'b0, 2'b11, 1'b0, 64'h0000_0000_0000_0010, 64'h0,                 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, 8'h00, 64'h0000_0000_0000_0010, 64'h0,                 64'hDEAD_BEEF_CAFE_F00D};
    vecs[9]  = '{1'b1, 1'b1, 2'b10, 1'b0, 64'h0000_0000_0000_0020, 64'h1111_2222_3333_4444, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0, 8'h00, 64'h0000_0000_0000_0020, 64'h0,                 64'h0000_0000_7FFF_FFFF};
    vecs[10] = '{1'b0, 1'b1, 2'b00, 1'b0, 64'h0000_0000_0000_0015, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0,                 1'b0, 1'b1, 8'h20, 64'h0000_0000_0000_0010, 64'h0000_AB00_0000_0000, 64'h0};
    vecs[11] = '{1'b0, 1'b1, 2'b11, 1'b0, 64'h0000_0000_0000_0008, 64'h0123_4567_89AB_CDEF, 64'h0,                 1'b0, 1'b1, 8'hFF, 64'h0000_0000_0000_0008, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[12] = '{1'b1, 1'b0, 2'b11, 1'b0, 64'h0000_0000_0000_0004, 64'h0,                 64'h0,                 1'b1, 1'b0, 8'h00, 64'h0,                 64'h0,                 64'h0};
    vecs[13] = '{1'b0, 1'b1, 2'b01, 1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_5555, 64'h0,                 1'b1, 1'b0, 8'h00, 64'h0,                 64'h0,                 64'h0};

    rst = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    last_rdata = '0;

    // Table: each access acked in its first REQ cycle.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive_req(vecs[i].ld, vecs[i].st, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      bus_ack = 1'b1; bus_rdata = vecs[i].rdata;
      @(negedge clk);
      idle_inputs();
      if (vecs[i].mis) begin
        check($sformatf("v%0d_misalign", i), lsu_misalign, 1'b1);
        check($sformatf("v%0d_no_req", i), bus_req, 1'b0);
        check($sformatf("v%0d_not_busy", i), lsu_busy, 1'b0);
        @(negedge clk);
        check($sformatf("v%0d_misalign_off", i), lsu_misalign, 1'b0);
        check($sformatf("v%0d_no_req2", i), bus_req, 1'b0);
        check($sformatf("v%0d_rdata_held", i), mem_rdata, last_rdata);
      end else begin
        for (int b = 0; b < 8; b++) lane_mask[8*b +: 8] = {8{vecs[i].strb[b]}};
        check($sformatf("v%0d_req", i), bus_req, 1'b1);
        check($sformatf("v%0d_we", i), bus_we, vecs[i].we);
        check($sformatf("v%0d_wstrb", i), bus_wstrb, vecs[i].strb);
        check($sformatf("v%0d_addr", i), bus_addr, vecs[i].baddr);
        check($sformatf("v%0d_wdata", i), bus_wdata & lane_mask, vecs[i].bwdata);
        check($sformatf("v%0d_busy_req", i), lsu_busy, 1'b1);
        check($sformatf("v%0d_no_done_yet", i), mem_done, 1'b0);
        @(negedge clk);
        check($sformatf("v%0d_done", i), mem_done, 1'b1);
        check($sformatf("v%0d_busy_done", i), lsu_busy, 1'b1);
        check($sformatf("v%0d_req_dropped", i), bus_req, 1'b0);
        check($sformatf("v%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
        last_rdata = vecs[i].exp_rdata;
        @(negedge clk);
        check($sformatf("v%0d_done_off", i), mem_done, 1'b0);
        check($sformatf("v%0d_idle", i), lsu_busy, 1'b0);
        check($sformatf("v%0d_rdata_hold", i), mem_rdata, last_rdata);
      end
      bus_ack = 1'b0;
    end

    // Dword load with ack held off for 5 REQ cycles; a competing store is ignored.
    @(negedge clk);
    drive_req(1'b1, 1'b0, 2'b11, 1'b0, 64'h0000_0000_0000_0040, 64'h0);
    bus_rdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 2'b11, 1'b0, 64'h0000_0000_0000_0100, 64'hFFFF_FFFF_FFFF_FFFF);
    held_addr = 64'h0000_0000_0000_0040;
    done_pulses = 0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("slow_req_c%0d", c), bus_req, 1'b1);
      check($sformatf("slow_addr_c%0d", c), bus_addr, held_addr);
      check($sformatf("slow_we_c%0d", c), bus_we, 1'b0);
      check($sformatf("slow_busy_c%0d", c), lsu_busy, 1'b1);
      if (mem_done) done_pulses++;
      if (c == 1) idle_inputs();
      if (c == 4) bus_ack = 1'b1;
      @(negedge clk);
    end
    check("slow_done", mem_done, 1'b1);
    check("slow_busy_done", lsu_busy, 1'b1);
    check("slow_rdata", mem_rdata, 64'h1122_3344_5566_7788);
    if (mem_done) done_pulses++;
    bus_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_done) done_pulses++;
    end
    check("slow_single_done", done_pulses, 1);
    check("slow_idle_busy", lsu_busy, 1'b0);
    check("slow_idle_req", bus_req, 1'b0);

    // Reset while in REQ, then a late ack must be ignored.
    @(negedge clk);
    drive_req(1'b1, 1'b0, 2'b00, 1'b0, 64'h0000_0000_0000_0201, 64'h0);
    bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    idle_inputs();
    check("rstreq_in_req", bus_req, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rstreq");
    rst = 1'b1; bus_ack = 1'b1;
    done_pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_done) done_pulses++;
      check($sformatf("rstreq_late_req_c%0d", c), bus_req, 1'b0);
      check($sformatf("rstreq_late_busy_c%0d", c), lsu_busy, 1'b0);
    end
    check("rstreq_no_done", done_pulses, 0);
    check("rstreq_rdata", mem_rdata, 64'h0);
    bus_ack = 1'b0;

    // Reset wins over a simultaneous valid request.
    @(negedge clk);
    rst = 1'b0;
    drive_req(1'b0, 1'b1, 2'b11, 1'b0, 64'h0000_0000_0000_0300, 64'h55);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    check("rstprio_req", bus_req, 1'b0);
    check("rstprio_busy", lsu_busy, 1'b0);

    // Valid without a load or store bit is ignored.
    @(negedge clk);
    ex_valid = 1'b1; ex_addr = 64'h0000_0000_0000_0003; ex_size = 2'b10;
    @(negedge clk);
    idle_inputs();
    check("nop_req", bus_req, 1'b0);
    check("nop_busy", lsu_busy, 1'b0);
    check("nop_misalign", lsu_misalign, 1'b0);
    @(negedge clk);
    check("nop_req2", bus_req, 1'b0);
    check("nop_done", mem_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: ysyx_22040125_LSU

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, synchronous active-low reset; sampled only at posedge clk.
REQ-003 SHALL have port ex_valid, input, 1, request from the execute pipeline register is present.
REQ-004 SHALL have ports ex_load and ex_store, input, 1 each, access type.
REQ-005 SHALL have port ex_size, input, 2: 00 byte, 01 half, 10 word, 11 dword.
REQ-006 SHALL have port ex_unsigned, input, 1, zero-extend load data when 1.
REQ-007 SHALL have ports ex_addr and ex_wdata, input, 64 each, byte address and store data in bits [8*size-1:0].
REQ-008 SHALL have port lsu_busy, output, 1, upstream stall request.
REQ-009 SHALL have port mem_done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port mem_rdata, output, 64, extended load result.
REQ-011 SHALL have port lsu_misalign, output, 1, one-cycle misalignment pulse.
REQ-012 SHALL have ports bus_req and bus_we, output, 1 each, bus request and write enable.
REQ-013 SHALL have ports bus_addr and bus_wdata, output, 64 each, plus bus_wstrb, output, 8.
REQ-014 SHALL have ports bus_ack, input, 1, and bus_rdata, input, 64.

Function
REQ-015 SHALL implement FSM states IDLE, REQ and DONE.
REQ-016 In IDLE with ex_valid=1 and ex_load or ex_store set and the address aligned, SHALL latch all request fields and enter REQ on the next edge.
REQ-017 If ex_load and ex_store are both set, SHALL perform a load.
REQ-018 Aligned means ex_addr[size-1:0]==0 (byte always aligned). On a misaligned request in IDLE, SHALL pulse lsu_misalign for one cycle next cycle, stay IDLE and issue no bus access.
REQ-019 In IDLE, SHALL ignore ex_valid when neither ex_load nor ex_store is set.
REQ-020 In REQ, SHALL hold bus_req=1 and keep bus_addr, bus_we, bus_wdata and bus_wstrb stable until bus_ack=1.
REQ-021 bus_addr SHALL be {addr[63:3],3'b000}.
REQ-022 bus_wstrb SHALL be 0x01/0x03/0x0F/0xFF for sizes 00/01/10/11, shifted left by addr[2:0]; store data SHALL be shifted left by 8*addr[2:0].
REQ-023 For loads, bus_we and bus_wstrb SHALL be 0.
REQ-024 bus_ack is valid only while bus_req=1; bus_ack=1 in the first REQ cycle SHALL be legal.
REQ-025 On bus_ack in REQ, SHALL capture bus_rdata and enter DONE.
REQ-026 In DONE, SHALL pulse mem_done=1 for exactly one cycle and return to IDLE.
REQ-027 mem_rdata SHALL be (bus_rdata >> 8*addr[2:0]) truncated to the access size, then sign- or zero-extended per ex_unsigned. Dword accesses SHALL not be extended. Stores SHALL return 0.
REQ-028 mem_rdata SHALL hold its value until the next completion.
REQ-029 lsu_busy SHALL be 1 in REQ and DONE, and 0 in IDLE.
REQ-030 Requests arriving while not IDLE SHALL be ignored; upstream holds them under lsu_busy.
REQ-031 Minimum latency SHALL be: request edge -> REQ; ack in that cycle -> DONE next edge; 3 cycles request to mem_done.

Reset
REQ-032 With rst=0 at a posedge, SHALL enter IDLE and set bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata, lsu_busy, mem_done, lsu_misalign and mem_rdata to 0.
REQ-033 Reset during REQ SHALL drop bus_req after that edge; a bus_ack arriving afterwards SHALL be ignored.
REQ-034 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-035 Byte load, signed, addr 0x80000003, bus_rdata 0x00000000_80000000, ack in the first REQ cycle -> bus_addr 0x80000000, mem_done 3 cycles after the request, mem_rdata 0xFFFFFFFF_FFFFFF80.
REQ-036 Half store, addr 0x80000006, wdata 0x1234 -> bus_we=1, bus_wstrb 0xC0, bus_wdata[63:48]=0x1234.
REQ-037 Word load, unsigned, addr 0x80000002 -> lsu_misalign pulse, bus_req never asserted, lsu_busy stays 0.
REQ-038 Dword load with bus_ack delayed 5 cycles -> bus_req and bus_addr stable for 5 cycles, lsu_busy high through DONE, single mem_done pulse.
REQ-039 rst=0 asserted during REQ, then ack -> all outputs 0, state IDLE, no mem_done.
REQ-040 ex_load and ex_store both 1 -> load performed, bus_we=0.
